// File: rtl/demux_1_4_stream.sv
// -----------------------------------------------------------------------------
// demux_1_4_stream
//
// Purpose:
//   Registered 1:4 stream demultiplexer. Words arrive on one valid/ready input.
//   Each word goes to exactly one of four valid/ready output channels. The
//   destination is either the per-word select or an internal round-robin
//   pointer. A single-entry holding register gives one cycle of latency. It
//   sustains one word per cycle while the targeted consumer is ready.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      producer has a word
//   in_ready   out  1      block can take a word this cycle
//   in_data    in   WIDTH  input word
//   in_sel     in   2      destination channel when in_rr = 0
//   in_rr      in   1      1 = use the round-robin pointer instead of in_sel
//   out_valid  out  4      one-hot; bit i = word pending for channel i
//   out_ready  in   4      bit i = channel i consumer can take the word
//   out_data   out  WIDTH  pending word, shared by all channels
//   out_count  out  8      completed output transfers, mod 256
//
// Handshake:
//   A transfer happens on a rising edge where valid and ready are both high.
//   Input side: valid must not depend on ready. Output side: once out_valid[i]
//   is raised, it stays high with out_data stable until out_ready[i] is seen
//   high at an edge. out_ready bits of channels that are not pending are
//   ignored.
// -----------------------------------------------------------------------------
module demux_1_4_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_rr,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_count
);

    // Holding register and bookkeeping state
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_dest;
    logic [1:0]       r_rr_ptr;
    logic [7:0]       r_count;

    logic             w_deq;
    logic             w_enq;
    logic [1:0]       w_dest_in;

    // Delivery only looks at the ready bit of the channel that holds the word.
    assign w_deq     = r_full && out_ready[r_dest];

    // The register can refill in the same cycle it drains. This gives full-rate
    // pass-through. It also makes in_ready depend combinationally on
    // out_ready[dest].
    assign in_ready  = !rst && (!r_full || out_ready[r_dest]);
    assign w_enq     = in_valid && in_ready;

    assign w_dest_in = in_rr ? r_rr_ptr : in_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full   <= 1'b0;
            r_data   <= '0;
            r_dest   <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_count  <= 8'd0;
        end else begin
            // enq wins over deq: a simultaneous enq/deq keeps the register full
            // and loads the new word. A deq on its own leaves data and dest
            // unchanged.
            if (w_enq) begin
                r_full <= 1'b1;
                r_data <= in_data;
                r_dest <= w_dest_in;
            end else if (w_deq) begin
                r_full <= 1'b0;
            end

            // Only words that actually used the pointer advance it.
            if (w_enq && in_rr) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end

            if (w_deq) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // One-hot decode of the registered full/dest pair. No input feeds this
    // path, so out_valid changes only on a clock edge or on reset.
    always_comb begin
        out_valid = 4'b0000;
        if (r_full) begin
            out_valid[r_dest] = 1'b1;
        end
    end

    assign out_data  = r_data;
    assign out_count = r_count;

endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_rr;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;
  logic [7:0]   out_count;

  demux_1_4_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_rr     (in_rr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The held word is a queue of at most one entry packed as {dest, data}.
  logic [W+1:0] exp_q[$];
  int           m_rr;
  int           m_count;
  logic [W-1:0] m_last_data;

  function automatic logic m_full();
    return exp_q.size() != 0;
  endfunction

  function automatic int m_dest();
    return (exp_q.size() != 0) ? int'(exp_q[0][W+1:W]) : 0;
  endfunction

  function automatic logic m_ready();
    if (rst) return 1'b0;
    if (!m_full()) return 1'b1;
    return out_ready[m_dest()];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_rr        = 0;
      m_count     = 0;
      m_last_data = '0;
    end else begin
      logic deq, enq;
      int   d;
      deq = m_full() && out_ready[m_dest()];
      enq = in_valid && m_ready();
      if (deq) begin
        void'(exp_q.pop_front());
        m_count = (m_count + 1) % 256;
      end
      if (enq) begin
        d = in_rr ? m_rr : int'(in_sel);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back({d[1:0], in_data});
        m_last_data = in_data;
        if (in_rr) m_rr = (m_rr + 1) % 4;
      end
    end
  end

  task automatic model_check();
    logic [3:0] ev;
    ev = m_full() ? (4'b0001 << m_dest()) : 4'b0000;
    check("in_ready",  in_ready,  m_ready());
    check("out_valid", out_valid, ev);
    check("out_data",  out_data,  m_last_data);
    check("out_count", out_count, m_count[7:0]);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs after the falling edge, then checks outputs
  // against the model before the next rising edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                     input logic r, input logic [3:0] o);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_rr     = r;
    out_ready = o;
    #1;
    model_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_valid", out_valid, 4'b0000);
    check("rst_ready", in_ready, 1'b0);
    check("rst_count", out_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", in_ready, 1'b1);
  endtask

  logic [3:0] rr_exp [0:7];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'd0; in_rr = 1'b0;
    out_ready = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset with a word held for channel 2
    cyc(1, 4'h6, 2'd2, 0, 4'b0000);
    cyc(0, 4'h0, 2'd0, 0, 4'b0000);
    check("pre_rst_valid", out_valid, 4'b0100);
    do_reset();

    // Explicit select
    cyc(1, 4'hA, 2'd2, 0, 4'b1111);
    cyc(1, 4'h5, 2'd0, 0, 4'b1111);
    check("sel_v0", out_valid, 4'b0100); check("sel_d0", out_data, 4'hA);
    cyc(1, 4'hF, 2'd3, 0, 4'b1111);
    check("sel_v1", out_valid, 4'b0001); check("sel_d1", out_data, 4'h5);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);
    check("sel_v2", out_valid, 4'b1000); check("sel_d2", out_data, 4'hF);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);
    check("sel_count", out_count, 8'd3);

    // Round robin with in_sel held at 3
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      cyc(1, 4'(i), 2'd3, 1, 4'b1111);
      check("rr_ready", in_ready, 1'b1);
      if (i > 0) check("rr_dest", out_valid, rr_exp[i-1]);
    end
    // The pointer must be back at 0: the next round-robin word goes to channel 0.
    cyc(1, 4'h8, 2'd3, 1, 4'b1111);
    check("rr_dest7", out_valid, 4'b1000);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);
    check("rr_wrap", out_valid, 4'b0001);

    // Mixed mode, pointer is now 1
    cyc(1, 4'hC, 2'd3, 0, 4'b1111);
    cyc(1, 4'hD, 2'd0, 1, 4'b1111);
    check("mix_sel", out_valid, 4'b1000);
    cyc(1, 4'hE, 2'd0, 1, 4'b1111);
    check("mix_rr", out_valid, 4'b0010);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);
    check("mix_ptr2", out_valid, 4'b0100);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);

    // Backpressure on channel 1
    cyc(1, 4'h9, 2'd1, 0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'h3, 2'd0, 0, 4'b0001);
      check("bp_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 4'b0010);
      check("bp_data",  out_data, 4'h9);
    end
    cyc(1, 4'h3, 2'd0, 0, 4'b0010);
    check("bp_release", in_ready, 1'b1);
    cyc(0, 4'h0, 2'd0, 0, 4'b0000);
    check("bp_next_v", out_valid, 4'b0001);
    check("bp_next_d", out_data, 4'h3);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);

    // Randomized traffic, with an occasional reset in the middle
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 1'($urandom),
          4'($urandom_range(0, 15)));
      if (i == 200) do_reset();
    end

    // Counter wrap: 257 transfers from a fresh reset
    do_reset();
    for (int i = 0; i < 257; i++) begin
      cyc(1, 4'($urandom), 2'($urandom), 1'($urandom), 4'b1111);
      if (i == 256) check("wrap_255", out_count, 8'd255);
    end
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);
    check("wrap_0", out_count, 8'd0);
    cyc(0, 4'h0, 2'd0, 0, 4'b1111);
    check("wrap_1", out_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
